// File: rtl/multi_tone_beeper_if.sv
// rtl/multi_tone_beeper_if.sv - request/config and buzzer-status bundle for multi_tone_beeper
interface multi_tone_beeper_if #(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 20,
    parameter int DUR_W  = 28
);
    logic [NUM_CH-1:0]       req;
    logic [NUM_CH*DIV_W-1:0] half_period;
    logic [NUM_CH*DUR_W-1:0] duration;
    logic                    stop;
    logic                    beep;
    logic                    busy;
    logic [2:0]              active_ch;
    logic                    done;

    modport master (
        output req, half_period, duration, stop,
        input  beep, busy, active_ch, done
    );

    modport slave (
        input  req, half_period, duration, stop,
        output beep, busy, active_ch, done
    );
endinterface

// File: rtl/multi_tone_beeper.sv
// rtl/multi_tone_beeper.sv - fixed-priority multi-channel square-wave tone player with preemption
module multi_tone_beeper #(
    parameter int NUM_CH  = 2,
    parameter int DIV_W   = 20,
    parameter int DUR_W   = 28,
    parameter int GAP_CYC = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    multi_tone_beeper_if.slave bus
);
    localparam int GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               beep_q, beep_d;
    logic               busy_q;
    logic               done_q, done_d;
    logic [2:0]         active_q, active_d;
    logic [NUM_CH-1:0]  pending_q, pending_d;
    logic [DIV_W-1:0]   hp_q, hp_d, hp_cnt_q, hp_cnt_d;
    logic [DUR_W-1:0]   dur_q, dur_d, dur_cnt_q, dur_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

    logic [NUM_CH-1:0]  cand;
    logic [NUM_CH-1:0]  win_oh;
    logic [2:0]         win;
    logic [DIV_W-1:0]   hp_sel;
    logic [DUR_W-1:0]   dur_sel;
    logic               grant;

    // Descending scan so the lowest set index is the last one written.
    always_comb begin
        cand    = pending_q | bus.req;
        win     = '0;
        win_oh  = '0;
        hp_sel  = '0;
        dur_sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win     = 3'(i);
                win_oh  = NUM_CH'(1) << i;
                hp_sel  = bus.half_period[i*DIV_W +: DIV_W];
                dur_sel = bus.duration[i*DUR_W +: DUR_W];
            end
        end
        grant = (|cand) && ((state_q == IDLE) || (win < active_q));
    end

    always_comb begin
        state_d   = state_q;
        beep_d    = beep_q;
        done_d    = 1'b0;
        active_d  = active_q;
        pending_d = cand;
        hp_d      = hp_q;
        dur_d     = dur_q;
        hp_cnt_d  = hp_cnt_q;
        dur_cnt_d = dur_cnt_q;
        gap_cnt_d = gap_cnt_q;

        if (bus.stop) begin
            state_d   = IDLE;
            beep_d    = 1'b0;
            pending_d = '0;
        end else if (grant) begin
            state_d   = TONE;
            hp_d      = (hp_sel == '0) ? DIV_W'(1) : hp_sel;
            dur_d     = (dur_sel == '0) ? DUR_W'(1) : dur_sel;
            active_d  = win;
            beep_d    = 1'b1;
            hp_cnt_d  = '0;
            dur_cnt_d = '0;
            pending_d = cand & ~win_oh;
        end else begin
            case (state_q)
                TONE: begin
                    if (dur_cnt_q == dur_q - DUR_W'(1)) begin
                        beep_d    = 1'b0;
                        gap_cnt_d = '0;
                        if (GAP_CYC == 0) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = GAP;
                        end
                    end else begin
                        dur_cnt_d = dur_cnt_q + DUR_W'(1);
                        if (hp_cnt_q == hp_q - DIV_W'(1)) begin
                            beep_d   = ~beep_q;
                            hp_cnt_d = '0;
                        end else begin
                            hp_cnt_d = hp_cnt_q + DIV_W'(1);
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            beep_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            active_q  <= '0;
            pending_q <= '0;
            hp_q      <= '0;
            dur_q     <= '0;
            hp_cnt_q  <= '0;
            dur_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            beep_q    <= beep_d;
            busy_q    <= (state_d != IDLE);
            done_q    <= done_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            hp_q      <= hp_d;
            dur_q     <= dur_d;
            hp_cnt_q  <= hp_cnt_d;
            dur_cnt_q <= dur_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign bus.beep      = beep_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.active_ch = active_q;
endmodule

// File: doc/multi_tone_beeper.md
# multi_tone_beeper

Parametrised beeper controller that plays timed square-wave tones on a single buzzer output for up to NUM_CH independent request channels. Each channel supplies its own half-period and duration in clock cycles, so no pre-divided tone clocks are needed. A fixed-priority arbiter queues requests, and lower-index channels preempt higher-index ones. Sits between system event logic (alarms, key clicks, timers) and the board buzzer pin.

## Interface
- NUM_CH, 2: number of request channels; 1..8.
- DIV_W, 20: width of each half-period field.
- DUR_W, 28: width of each duration field.
- GAP_CYC, 1000: silent clock cycles inserted after every completed tone; 0 = no gap.
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NUM_CH  per-channel one-cycle request pulse; bit 0 = highest priority.
- half_period  input  NUM_CH*DIV_W  per-channel tone half-period in cycles; channel i in bits [i*DIV_W +: DIV_W]; 0 treated as 1.
- duration  input  NUM_CH*DUR_W  per-channel tone length in cycles; 0 treated as 1.
- stop  input  1  synchronous abort of everything.
- beep  output  1  buzzer drive, registered.
- busy  output  1  high in TONE or GAP.
- active_ch  output  3  index of the channel being played or last played.
- done  output  1  one-cycle pulse when a tone plus its gap completes normally.

## Operation
- Reset values: beep=0, busy=0, active_ch=0, done=0, pending=0, state=IDLE, all counters 0.
- pending[NUM_CH-1:0] register: bit i sets on req[i]. It clears when channel i is granted or when stop is asserted.
- Candidate set = pending | req. Winner = lowest set index.
- IDLE: if the candidate set is non-empty and stop=0:
  - Go to TONE and latch hp = max(half_period[win],1) and dur = max(duration[win],1).
  - active_ch=win, beep=1, hp_cnt=0, dur_cnt=0, and clear pending[win].
- TONE, each cycle:
  - hp_cnt increments. At hp_cnt==hp-1, beep toggles and hp_cnt returns to 0.
  - dur_cnt increments. At dur_cnt==dur-1 the next state is GAP (or IDLE if GAP_CYC=0) and beep=0.
- GAP: beep=0; count GAP_CYC cycles, then go to IDLE with done=1 for that one cycle.
- With GAP_CYC=0, done pulses on the TONE-to-IDLE edge.
- Preemption (TONE or GAP): if the candidate set contains an index below active_ch, restart TONE for that channel, exactly as granting from IDLE.
  - The preempted tone is discarded: no done, and it is not re-queued.
- A request for the active channel or for a lower-priority channel during TONE/GAP only sets pending. It is served after the current tone's GAP completes.
- stop=1 in any state: next edge gives state=IDLE, beep=0, pending=0, done=0. stop overrides req in the same cycle.
- busy = (state != IDLE), registered together with state.
- Width rules: counters are DIV_W and DUR_W bits. hp and dur reach up to 2^W-1 without wrap. The GAP counter is clog2(GAP_CYC+1) bits.

## Timing
- Request latency: req[i] sampled high at edge k in IDLE gives beep=1, busy=1 and active_ch=i after edge k.
- The tone occupies exactly dur cycles of beep activity. The waveform is hp cycles high, then hp low, repeating, always starting high. A final partial half-period is truncated.
- The gap is exactly GAP_CYC cycles of beep=0 after the last TONE cycle. done asserts on the cycle state returns to IDLE.
- Back-to-back: a pending request is granted on the edge after the done cycle. There is one IDLE cycle between tones.
- Preemption takes effect on the edge that samples the higher-priority req, and beep=1 immediately.
- Reset asserted mid-tone: beep falls asynchronously to 0, with no done.

## Test plan
- Reset: hold rst_n=0 with req=all ones -> beep=0, busy=0, done=0, active_ch=0. Release -> idle until the next req.
- Basic tone: GAP_CYC=4, ch0 hp=2, dur=10, one req pulse -> beep over 10 cycles is 1,1,0,0,1,1,0,0,1,1, then 4 zero cycles. done pulses once on the 15th cycle after req; busy high for 14 cycles.
- Degenerate values: hp=0, dur=0 on ch1 -> single cycle beep=1, active_ch=1, then gap and done, as if hp=1, dur=1.
- Queueing: req[0] and req[1] in the same cycle (hp=3, dur=6 each) -> ch0 plays first, done, one IDLE cycle, then ch1 plays and a second done.
- Preemption: ch1 playing (dur=100); req[0] at tone cycle 20 -> beep=1 for ch0 on the next cycle, active_ch=0, no done for ch1. Exactly one done at the end of ch0's tone.
- Stop: stop asserted mid-TONE while req[1] is pending and req[0] is pulsed in the same cycle -> next cycle IDLE, beep=0, busy=0, and no tone follows.
